// File: rtl/fft_bram_writer_mc.sv
// Serialises multichannel FFT beats (one bin, NUM_CH complex samples) into
// sign-extended dual-bus BRAM writes with selectable layout and ping-pong banks.
module fft_bram_writer_mc #(
   parameter int unsigned NUM_CH      = 8,
   parameter int unsigned SAMPLE_W    = 24,
   parameter int unsigned BRAM_DW     = 32,
   parameter int unsigned FFT_LEN     = 256,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned ADDR_STRIDE = 4,
   parameter int unsigned BASE_ADDR   = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH*2*SAMPLE_W-1:0] s_axis_tdata,
   input  logic                         s_axis_tvalid,
   input  logic                         s_axis_tlast,
   output logic                         s_axis_tready,
   input  logic                         layout_mode,
   output logic [ADDR_W-1:0]            bram_addr,
   output logic [BRAM_DW-1:0]           bram_din_re,
   output logic [BRAM_DW-1:0]           bram_din_im,
   output logic [BRAM_DW/8-1:0]         bram_we,
   output logic                         bram_en,
   output logic                         bram_rst,
   output logic                         frame_done,
   output logic                         frame_bank,
   output logic                         tlast_err
);

   localparam int unsigned CH_W = $clog2(NUM_CH);
   localparam int unsigned BIN_W = $clog2(FFT_LEN);
   localparam int unsigned TD_W = NUM_CH * 2 * SAMPLE_W;
   localparam int unsigned WE_W = BRAM_DW / 8;

   typedef enum logic {
      S_IDLE,
      S_WRITE
   } state_t;

   state_t                     state_q;
   logic [CH_W-1:0]            ch_q;
   logic [BIN_W-1:0]           bin_q;
   logic [BIN_W-1:0]           bin_d;
   logic                       bank_q;
   logic                       bank_d;
   logic                       mode_q;
   logic [TD_W-1:0]            beat_q;
   logic                       last_q;

   logic [ADDR_W-1:0]          addr_q;
   logic [BRAM_DW-1:0]         re_q;
   logic [BRAM_DW-1:0]         im_q;
   logic                       we_q;
   logic                       done_q;
   logic                       fbank_q;
   logic                       err_q;

   logic                       last_ch;
   logic                       bin_end;
   logic                       accept;
   logic signed [SAMPLE_W-1:0] re_sel;
   logic signed [SAMPLE_W-1:0] im_sel;
   logic [ADDR_W-1:0]          word;
   logic [ADDR_W-1:0]          addr_nxt;

   assign last_ch = (state_q == S_WRITE) && (ch_q == CH_W'(NUM_CH - 1));
   assign bin_end = (bin_q == BIN_W'(FFT_LEN - 1));
   assign s_axis_tready = !rst && ((state_q == S_IDLE) || last_ch);
   assign accept = s_axis_tvalid && s_axis_tready;

   // Channel mux out of the captured beat
   always_comb begin
      re_sel = '0;
      im_sel = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_q == CH_W'(k)) begin
            re_sel = beat_q[k*2*SAMPLE_W +: SAMPLE_W];
            im_sel = beat_q[k*2*SAMPLE_W+SAMPLE_W +: SAMPLE_W];
         end
      end
   end

   // Power-of-two sizes make the word index a plain field concatenation
   always_comb begin
      if (mode_q) begin
         word = ADDR_W'({bank_q, ch_q, bin_q});
      end else begin
         word = ADDR_W'({bank_q, bin_q, ch_q});
      end
      addr_nxt = ADDR_W'(BASE_ADDR) + word * ADDR_W'(ADDR_STRIDE);
   end

   // Frame position after the current beat's last channel
   always_comb begin
      bin_d  = bin_q;
      bank_d = bank_q;
      if (last_ch) begin
         if (bin_end || last_q) begin
            bin_d = '0;
         end else begin
            bin_d = bin_q + BIN_W'(1);
         end
         if (bin_end) begin
            bank_d = ~bank_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         bin_q   <= '0;
         bank_q  <= 1'b0;
         mode_q  <= 1'b0;
         beat_q  <= '0;
         last_q  <= 1'b0;
         addr_q  <= ADDR_W'(BASE_ADDR);
         re_q    <= '0;
         im_q    <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         fbank_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         bin_q  <= bin_d;
         bank_q <= bank_d;
         // The mode follows the bin the accepted beat will occupy
         if (accept) begin
            beat_q <= s_axis_tdata;
            last_q <= s_axis_tlast;
            if (bin_d == '0) begin
               mode_q <= layout_mode;
            end
         end
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  ch_q    <= '0;
                  state_q <= S_WRITE;
               end
            end
            S_WRITE: begin
               addr_q <= addr_nxt;
               re_q   <= BRAM_DW'(re_sel);
               im_q   <= BRAM_DW'(im_sel);
               we_q   <= 1'b1;
               if (last_ch) begin
                  done_q <= bin_end;
                  err_q  <= bin_end ^ last_q;
                  if (bin_end) begin
                     fbank_q <= bank_q;
                  end
                  ch_q <= '0;
                  if (!accept) begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  ch_q <= ch_q + CH_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bram_addr   = addr_q;
   assign bram_din_re = re_q;
   assign bram_din_im = im_q;
   assign bram_we     = {WE_W{we_q}};
   assign bram_en     = 1'b1;
   assign bram_rst    = rst;
   assign frame_done  = done_q;
   assign frame_bank  = fbank_q;
   assign tlast_err   = err_q;

endmodule
